// File: rtl/motor_pkg.sv
// Shared constants for the motor steering block: FSM encodings, image centre and PWM width.
package motor_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_SEARCH = 2'd2;

  localparam int unsigned C_IMG_COLS   = 80;
  localparam int unsigned C_CENTRE_COL = C_IMG_COLS / 2;
  localparam int unsigned C_PWM_BITS   = 8;

endpackage

// File: rtl/pwm_gen.sv
// Single PWM channel: period counter, shadowed duty and registered comparator output.
module pwm_gen #(
  parameter int unsigned c_pwm_bits = motor_pkg::C_PWM_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [c_pwm_bits-1:0] duty,
  input  logic                  force_off,
  output logic                  pwm
);

  // Counter runs 0..2^bits-2 so that duty = 2^bits-1 gives a constant high output.
  localparam logic [c_pwm_bits-1:0] CntMax = {{(c_pwm_bits-1){1'b1}}, 1'b0};

  logic [c_pwm_bits-1:0] cnt_q, cnt_d;
  logic [c_pwm_bits-1:0] shadow_q, shadow_d;
  logic                  pwm_q, pwm_d;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (tick) begin
      if (cnt_q == CntMax) begin
        cnt_d    = '0;
        shadow_d = duty;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pwm_d = !force_off && (cnt_d < shadow_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/motor_steer.sv
// Turns the per-frame winning red column into differential motor PWM, with target-loss
// search and a frame watchdog so the robot never drives on stale data.
module motor_steer
  import motor_pkg::*;
#(
  parameter int unsigned c_nb_col      = 7,
  parameter int unsigned c_nb_hits     = 6,
  parameter int unsigned c_pwm_bits    = C_PWM_BITS,
  parameter int unsigned c_pwm_div     = 196,
  parameter int unsigned c_duty_base   = 128,
  parameter int unsigned c_gain_sh     = 1,
  parameter int unsigned c_dead_zone   = 2,
  parameter int unsigned c_min_hits    = 4,
  parameter int unsigned c_lost_frames = 8,
  parameter int unsigned c_duty_search = 96,
  parameter int unsigned c_wd_cycles   = 4000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_done,
  input  logic [c_nb_col-1:0]  col_in,
  input  logic [c_nb_hits-1:0] hits_in,
  output logic                 pwm_l,
  output logic                 pwm_r,
  output logic                 dir_l,
  output logic                 dir_r,
  output logic                 tracking
);

  localparam int unsigned PrescW = (c_pwm_div > 1) ? $clog2(c_pwm_div) : 1;
  localparam int unsigned WdW    = $clog2(c_wd_cycles + 1);
  localparam int unsigned MissW  = $clog2(c_lost_frames + 1);

  localparam logic signed [10:0] Centre  = 11'(C_CENTRE_COL);
  localparam logic signed [10:0] Dz      = 11'(c_dead_zone);
  localparam logic signed [10:0] Base    = 11'(c_duty_base);
  localparam logic signed [10:0] DutyMax = 11'((1 << c_pwm_bits) - 1);

  function automatic logic [c_pwm_bits-1:0] sat(input logic signed [10:0] s);
    if (s < 0) return '0;
    else if (s > DutyMax) return '1;
    else return s[c_pwm_bits-1:0];
  endfunction

  logic [1:0]            state_q, state_d;
  logic [c_pwm_bits-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic                  dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic [MissW-1:0]      miss_q, miss_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [PrescW-1:0]     presc_q, presc_d;
  logic                  last_sign_q, last_sign_d;

  logic signed [10:0] err_raw, err, off;
  logic [c_pwm_bits-1:0] new_l, new_r;
  logic valid, tick, wd_expired, force_off;

  always_comb begin
    err_raw = $signed(11'(col_in)) - Centre;
    err     = (err_raw <= Dz && err_raw >= -Dz) ? 11'sd0 : err_raw;
    off     = err <<< c_gain_sh;
    new_l   = sat(Base + off);
    new_r   = sat(Base - off);
  end

  assign valid      = frame_done && (hits_in >= c_nb_hits'(c_min_hits));
  // A frame in the expiry cycle still counts, so the watchdog yields to frame_done.
  assign wd_expired = (wd_q >= WdW'(c_wd_cycles)) && !frame_done;
  assign tick       = (presc_q == PrescW'(c_pwm_div - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    if (frame_done) wd_d = '0;
    else if (wd_q < WdW'(c_wd_cycles)) wd_d = wd_q + 1'b1;
    else wd_d = wd_q;
  end

  always_comb begin
    state_d     = state_q;
    duty_l_d    = duty_l_q;
    duty_r_d    = duty_r_q;
    dir_l_d     = dir_l_q;
    dir_r_d     = dir_r_q;
    miss_d      = miss_q;
    last_sign_d = last_sign_q;
    if (!enable || wd_expired) begin
      state_d  = S_IDLE;
      duty_l_d = '0;
      duty_r_d = '0;
      dir_l_d  = 1'b1;
      dir_r_d  = 1'b1;
      miss_d   = '0;
    end else if (valid) begin
      state_d     = S_TRACK;
      duty_l_d    = new_l;
      duty_r_d    = new_r;
      dir_l_d     = 1'b1;
      dir_r_d     = 1'b1;
      miss_d      = '0;
      last_sign_d = err[10];
    end else if (frame_done && state_q == S_TRACK) begin
      if (miss_q == MissW'(c_lost_frames - 1)) begin
        state_d  = S_SEARCH;
        duty_l_d = c_pwm_bits'(c_duty_search);
        duty_r_d = c_pwm_bits'(c_duty_search);
        // Rotate toward the side where the target was last seen.
        dir_l_d  = !last_sign_q;
        dir_r_d  = last_sign_q;
        miss_d   = '0;
      end else begin
        miss_d = miss_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      duty_l_q    <= '0;
      duty_r_q    <= '0;
      dir_l_q     <= 1'b1;
      dir_r_q     <= 1'b1;
      miss_q      <= '0;
      wd_q        <= '0;
      presc_q     <= '0;
      last_sign_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_l_q    <= duty_l_d;
      duty_r_q    <= duty_r_d;
      dir_l_q     <= dir_l_d;
      dir_r_q     <= dir_r_d;
      miss_q      <= miss_d;
      wd_q        <= wd_d;
      presc_q     <= presc_d;
      last_sign_q <= last_sign_d;
    end
  end

  assign force_off = (state_d == S_IDLE);

  pwm_gen #(.c_pwm_bits(c_pwm_bits)) u_pwm_l (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .duty     (duty_l_q),
    .force_off(force_off),
    .pwm      (pwm_l)
  );

  pwm_gen #(.c_pwm_bits(c_pwm_bits)) u_pwm_r (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .duty     (duty_r_q),
    .force_off(force_off),
    .pwm      (pwm_r)
  );

  assign dir_l    = dir_l_q;
  assign dir_r    = dir_r_q;
  assign tracking = (state_q == S_TRACK);

endmodule

// File: doc/motor_steer.md
Name: motor_steer

Overview:
- Downstream of the colour-processing stage in the motor proof-of-concept.
- Once per frame it takes the winning red column and that column's red-pixel count. It turns them into a steering error.
- Outputs are two glitch-free PWM streams plus direction bits for the left and right motor drivers.
- A tracking FSM handles a lost target and a stalled camera, so the robot never keeps driving on stale data.

Parameters:
- c_img_cols, 80, image width in pixels; the centre column is c_img_cols/2 = 40.
- c_nb_col, 7, bit width of the column input.
- c_nb_hits, 6, bit width of the per-column red count.
- c_pwm_bits, 8, PWM resolution.
- c_pwm_div, 196, clock cycles per PWM tick (12 MHz gives roughly 240 Hz).
- c_duty_base, 128, forward duty when the error is zero.
- c_gain_sh, 1, left-shift applied to the error to form the duty offset.
- c_dead_zone, 2, error magnitude at or below which the error is treated as 0.
- c_min_hits, 4, minimum red count for a frame to count as a valid target.
- c_lost_frames, 8, consecutive invalid frames before entering SEARCH.
- c_duty_search, 96, duty used while rotating in place.
- c_wd_cycles, 4000000, cycles without frame_done before forcing IDLE.

Ports:
- clk, in, 1, FPGA clock.
- rst, in, 1, synchronous reset, active high.
- enable, in, 1, motor run enable (level).
- frame_done, in, 1, one-cycle pulse; col_in and hits_in are valid in that cycle.
- col_in, in, c_nb_col, column with the most red pixels.
- hits_in, in, c_nb_hits, red count in that column.
- pwm_l, out, 1, left motor PWM.
- pwm_r, out, 1, right motor PWM.
- dir_l, out, 1, left motor direction; 1 = forward.
- dir_r, out, 1, right motor direction; 1 = forward.
- tracking, out, 1, high when the state is TRACK.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state = IDLE;
  - pwm_l = pwm_r = 0;
  - dir_l = dir_r = 1;
  - tracking = 0;
  - duty and shadow registers = 0;
  - miss counter, watchdog counter, prescaler and PWM counter = 0;
  - last_sign = 0.
- Error computation:
  - err = signed(col_in) - 40, range -40..+39.
  - If |err| <= c_dead_zone, err = 0.
  - off = err << c_gain_sh.
  - duty_l = sat(c_duty_base + off) and duty_r = sat(c_duty_base - off), where sat clamps to 0..2^c_pwm_bits-1.
  - Intermediates are at least 11 bits signed.
- A frame is valid when frame_done = 1 and hits_in >= c_min_hits.
- Latency: frame_done in cycle t registers the new duty in cycle t+1. The duty is copied into the pwm_gen shadow at the next PWM period start and never mid-period.
- PWM timing:
  - The prescaler counts 0..c_pwm_div-1 and produces a tick on wrap.
  - pwm_cnt advances on each tick through 0..2^c_pwm_bits-2 and wraps; a period is 255 ticks.
  - Output is high while pwm_cnt < duty, so duty 255 = 100% and duty 0 = constantly low.
- FSM states: IDLE, TRACK, SEARCH.
  - IDLE:
    - Duties 0, dir = 1.
    - Goes to TRACK on a valid frame while enable = 1, loading the duty from that frame.
  - TRACK:
    - A valid frame updates the duty, clears the miss counter and sets last_sign = (err < 0).
    - An invalid frame increments the miss counter and holds the previous duty.
    - When the miss counter reaches c_lost_frames, go to SEARCH.
  - SEARCH:
    - Both duties = c_duty_search.
    - If last_sign = 1: dir_l = 0, dir_r = 1 (rotate left). Otherwise dir_l = 1, dir_r = 0.
    - A valid frame returns to TRACK with the fresh duty and sets dir_l = dir_r = 1.
- Any state goes to IDLE when:
  - enable = 0, or
  - the watchdog counter reaches c_wd_cycles; frame_done clears the watchdog counter.
- On entering IDLE, pwm_l and pwm_r are forced low from the next cycle, bypassing the shadow.
- Simultaneous events:
  - enable = 0 together with frame_done: IDLE wins.
  - Watchdog expiry together with frame_done: frame_done wins.
  - rst overrides everything, including mid-period PWM.

Decomposition:
- Shared package/include, motor_pkg, holding:
  - state encodings S_IDLE = 0, S_TRACK = 1, S_SEARCH = 2;
  - the centre column constant;
  - the PWM width constant.
- Sub-module pwm_gen, instantiated twice:
  - parameters c_pwm_bits;
  - ports: tick, duty, force_off, pwm;
  - contains the pwm_cnt, the shadow register and the comparator.
- One prescaler in motor_steer is shared by both instances.

Test Plan:
1. Reset, then idle for 2 periods -> pwm_l = pwm_r = 0, dir_l = dir_r = 1, tracking = 0.
2. enable = 1; frame_done with col = 60, hits = 10 -> tracking = 1, duty_l = 168, duty_r = 88. Over one full period, pwm_l is high for 168*c_pwm_div cycles; there is no change mid-period.
3. col = 41 and col = 38, hits = 10 -> dead zone gives duty 128/128. col = 0 -> duty_l = 48, duty_r = 208. With c_gain_sh = 3 and col = 79 -> duty_l = 255 (constant high), duty_r = 0 (constant low).
4. TRACK with col = 20, then 7 frames with hits = 2 -> stays TRACK at 88/168. The 8th invalid frame -> SEARCH, dir_l = 0, dir_r = 1, both duties 96. A following valid frame -> TRACK, dir = 1/1.
5. With c_wd_cycles = 1000: no frame_done for 1000 cycles -> IDLE and pwm low. Separately, enable = 0 asserted in the same cycle as a valid frame -> IDLE, and the frame is ignored.
6. Assert rst mid-period while in SEARCH -> the next cycle shows all reset values.
